instruction_fetcher: RTL and testbench

//  Fetch stage directly downstream of the PC stage. Latches the current PC, reads the
//  32-bit instruction as four byte reads through the shared byte-wide memory port, and

---
 rtl/instruction_fetcher_pkg.sv | 21 ++
 rtl/instruction_fetcher_inst_byte_assembler.sv | 42 ++++
 rtl/instruction_fetcher.sv | 108 ++++++++++
 tb/tb_instruction_fetcher.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// ============================================================================
// instruction_fetcher_pkg : shared state encodings and sizing for the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package instruction_fetcher_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_t;

  localparam int INST_BYTES = 4;
  localparam int ISS_CNT_W  = $clog2(INST_BYTES) + 1;
  localparam int RCV_CNT_W  = $clog2(INST_BYTES);

endpackage

`default_nettype wire

// File: rtl/instruction_fetcher_inst_byte_assembler.sv
// ============================================================================
// inst_byte_assembler : packs returning bytes little-endian into one word
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_byte_assembler
  import instruction_fetcher_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_byte,
  input  logic                    i_valid,
  input  logic                    i_clear,
  output logic [INST_BYTES*8-1:0] o_word,
  output logic                    o_done
);

  localparam logic [RCV_CNT_W-1:0] c_LAST = RCV_CNT_W'(INST_BYTES - 1);

  logic [RCV_CNT_W-1:0]    r_rcv_cnt;
  logic [INST_BYTES*8-1:0] r_word;

  // Clear beats an arriving byte so a byte in flight across a flush is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcv_cnt <= '0;
      r_word    <= '0;
    end else if (i_clear) begin
      r_rcv_cnt <= '0;
    end else if (i_valid) begin
      r_word[{r_rcv_cnt, 3'b000} +: 8] <= i_byte;
      r_rcv_cnt                        <= r_rcv_cnt + 1'b1;
    end
  end

  assign o_word = r_word;
  assign o_done = i_valid && !i_clear && (r_rcv_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/instruction_fetcher.sv
// ============================================================================
// instruction_fetcher : fetches a 32-bit instruction as four byte reads and
// hands it to the decoder over valid/ready. Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_advance,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_din,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam logic [ISS_CNT_W-1:0] c_ISS_MAX = ISS_CNT_W'(INST_BYTES);

  if_state_t               r_state;
  logic [ADDR_WIDTH-1:0]   r_fetch_pc;
  logic [ISS_CNT_W-1:0]    r_iss_cnt;
  logic                    r_pend;
  logic                    r_inst_valid;
  logic [ADDR_WIDTH-1:0]   r_inst_pc;

  logic                    w_grant;
  logic                    w_clear;
  logic                    w_done;
  logic [INST_BYTES*8-1:0] w_word;

  assign mem_req    = rdy && (r_state == IF_FETCH) && (r_iss_cnt < c_ISS_MAX);
  assign mem_addr   = (r_state == IF_FETCH) ? r_fetch_pc + ADDR_WIDTH'(r_iss_cnt) : '0;
  assign pc_advance = rdy && !flush && (r_state == IF_HOLD) && r_inst_valid && inst_ready;
  assign w_grant    = mem_req && mem_gnt;
  assign w_clear    = rdy && flush;

  inst_byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .i_byte  (mem_din),
    .i_valid (r_pend),
    .i_clear (w_clear),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  // Byte capture and completion run even while rdy is low, so a read granted
  // before a stall still lands and cannot leave the FSM waiting forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IF_IDLE;
      r_fetch_pc   <= '0;
      r_iss_cnt    <= '0;
      r_pend       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
    end else if (w_clear) begin
      r_state      <= IF_IDLE;
      r_iss_cnt    <= '0;
      r_pend       <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_pend <= w_grant;
      if (w_done) begin
        r_inst_valid <= 1'b1;
        r_inst_pc    <= r_fetch_pc;
        r_state      <= IF_HOLD;
      end else if (rdy) begin
        case (r_state)
          IF_IDLE: begin
            r_fetch_pc <= pc_in;
            r_iss_cnt  <= '0;
            r_state    <= IF_FETCH;
          end
          IF_FETCH: begin
            if (w_grant) r_iss_cnt <= r_iss_cnt + 1'b1;
          end
          IF_HOLD: begin
            if (inst_ready) begin
              r_inst_valid <= 1'b0;
              r_state      <= IF_IDLE;
            end
          end
          default: r_state <= IF_IDLE;
        endcase
      end
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst_pc    = r_inst_pc;
  assign inst_out   = w_word;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
// ============================================================================
// tb_instruction_fetcher : directed bench for the fetch stage with a byte memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [16:0] pc_in;
  logic        pc_advance;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [16:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetcher #(.ADDR_WIDTH(17), .INST_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .pc_in      (pc_in),
    .pc_advance (pc_advance),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_din    (mem_din),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [16:0] a);
    case (a)
      17'h00010: return 8'h13;
      17'h00011: return 8'h05;
      17'h00012: return 8'h00;
      17'h00013: return 8'h00;
      default:   return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Byte memory: a request granted in one cycle returns its data in the next.
  logic        m_gnt;
  logic [16:0] m_addr;
  initial begin
    m_gnt   = 1'b0;
    m_addr  = '0;
    mem_din = 8'h00;
  end
  always @(negedge clk) begin
    m_gnt  = mem_req && mem_gnt;
    m_addr = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    mem_din = m_gnt ? mem_byte(m_addr) : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; pc_in = 17'h00010;
    mem_gnt = 1'b1; inst_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_req",   32'(mem_req),    32'h0);
    chk("rst_addr",  32'(mem_addr),   32'h0);
    chk("rst_adv",   32'(pc_advance), 32'h0);
    chk("rst_inst",  inst_out,        32'h0);
    chk("rst_pc",    32'(inst_pc),    32'h0);

    // Reset asserted in the middle of a fetch
    rst = 1'b1;
    tick(); tick(); tick();
    chk("t1_req_c3",  32'(mem_req),  32'h1);
    chk("t1_addr_c3", 32'(mem_addr), 32'h00012);
    rst = 1'b0;
    #1;
    chk("t1_req_rst",   32'(mem_req),  32'h0);
    chk("t1_addr_rst",  32'(mem_addr), 32'h0);
    chk("t1_inst_rst",  inst_out,      32'h0);
    chk("t1_valid_rst", 32'(inst_valid), 32'h0);
    tick();
    rst = 1'b1;

    // Basic fetch, then decoder stalls for five cycles
    chk("t2_idle_req", 32'(mem_req), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t2_addr", 32'(mem_addr), 32'h00010 + 32'(c - 1));
    end
    tick();
    chk("t2_c5_valid", 32'(inst_valid), 32'h0);
    chk("t2_c5_req",   32'(mem_req),    32'h0);
    tick();
    chk("t2_c6_valid", 32'(inst_valid), 32'h1);
    chk("t2_c6_inst",  inst_out,        32'h00000513);
    chk("t2_c6_pc",    32'(inst_pc),    32'h00010);
    chk("t4_adv_c6",   32'(pc_advance), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t4_inst",  inst_out,        32'h00000513);
      chk("t4_pc",    32'(inst_pc),    32'h00010);
      chk("t4_valid", 32'(inst_valid), 32'h1);
      chk("t4_adv",   32'(pc_advance), 32'h0);
    end
    inst_ready = 1'b1; pc_in = 17'h00014;
    #1;
    chk("t2_adv", 32'(pc_advance), 32'h1);
    tick();
    inst_ready = 1'b0;
    #1;
    chk("t2_adv_off",   32'(pc_advance), 32'h0);
    chk("t2_valid_off", 32'(inst_valid), 32'h0);
    chk("t2_idle_req2", 32'(mem_req),    32'h0);

    // Lost grants in cycles 2 and 3
    tick(); chk("t3_addr_c1", 32'(mem_addr), 32'h00014);
    tick(); chk("t3_addr_c2", 32'(mem_addr), 32'h00015);
    mem_gnt = 1'b0;
    tick(); chk("t3_addr_c3", 32'(mem_addr), 32'h00015);
    tick(); mem_gnt = 1'b1;
    chk("t3_addr_c4", 32'(mem_addr), 32'h00015);
    tick(); chk("t3_addr_c5", 32'(mem_addr), 32'h00016);
    tick(); chk("t3_addr_c6", 32'(mem_addr), 32'h00017);
    tick(); chk("t3_valid_c7", 32'(inst_valid), 32'h0);
    tick();
    chk("t3_valid_c8", 32'(inst_valid), 32'h1);
    chk("t3_inst",     inst_out,        32'hB2B3B0B1);
    chk("t3_pc",       32'(inst_pc),    32'h00014);
    inst_ready = 1'b1; pc_in = 17'h00018;
    #1;
    chk("t3_adv", 32'(pc_advance), 32'h1);
    tick();
    inst_ready = 1'b0;

    // Flush with byte 1 outstanding
    tick(); chk("t5_addr_c1", 32'(mem_addr), 32'h00018);
    tick(); chk("t5_addr_c2", 32'(mem_addr), 32'h00019);
    tick();
    flush = 1'b1; pc_in = 17'h00100;
    #1;
    chk("t5_adv_flush", 32'(pc_advance), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("t5_idle_req",   32'(mem_req),    32'h0);
    chk("t5_idle_valid", 32'(inst_valid), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_addr", 32'(mem_addr), 32'h00100 + 32'(c));
    end
    tick(); tick();
    chk("t5_valid", 32'(inst_valid), 32'h1);
    chk("t5_inst",  inst_out,        32'hA6A7A4A5);
    chk("t5_pc",    32'(inst_pc),    32'h00100);

    // Flush coinciding with the handshake drops the instruction
    inst_ready = 1'b1; flush = 1'b1; pc_in = 17'h1FFFE;
    #1;
    chk("t5_adv_fh", 32'(pc_advance), 32'h0);
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    #1;
    chk("t5_fh_valid", 32'(inst_valid), 32'h0);
    chk("t5_fh_req",   32'(mem_req),    32'h0);

    // Address wrap, with a one-cycle rdy stall while byte 1 is in flight
    tick(); chk("t6_addr_c1", 32'(mem_addr), 32'h1FFFE);
    tick(); chk("t6_addr_c2", 32'(mem_addr), 32'h1FFFF);
    tick();
    rdy = 1'b0;
    #1;
    chk("t6_stall_req", 32'(mem_req), 32'h0);
    tick();
    rdy = 1'b1;
    #1;
    chk("t6_req_c4",  32'(mem_req),  32'h1);
    chk("t6_addr_c4", 32'(mem_addr), 32'h00000);
    tick(); chk("t6_addr_c5", 32'(mem_addr), 32'h00001);
    tick(); chk("t6_valid_c6", 32'(inst_valid), 32'h0);
    tick();
    chk("t6_valid_c7", 32'(inst_valid), 32'h1);
    chk("t6_inst",     inst_out,        32'hA4A55A5B);
    chk("t6_pc",       32'(inst_pc),    32'h1FFFE);
    inst_ready = 1'b1; rdy = 1'b0;
    #1;
    chk("t6_adv_nordy", 32'(pc_advance), 32'h0);
    tick();
    chk("t6_valid_hold", 32'(inst_valid), 32'h1);
    rdy = 1'b1;
    #1;
    chk("t6_adv", 32'(pc_advance), 32'h1);
    tick();
    inst_ready = 1'b0;
    #1;
    chk("t6_valid_off", 32'(inst_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
